led_blink_sched: RTL and testbench

Programmable LED blink scheduler that drives a status LED with a repeating bit pattern. It replaces ripple-clocked division with a single-clock clock-enable tick. A config handshake loads the step period, the 8-bit pattern and the repeat count, and the block then sequences the pattern onto `led`. It sits between board-level control logic and the LED pin.

---
 rtl/blink_pkg.sv | 15 +
 rtl/tick_gen.sv | 44 ++++
 rtl/led_blink_sched.sv | 129 ++++++++++++
 tb/tb_led_blink_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink scheduler.
//   - Default widths for the step-period counter, pattern length and repeat count.
//   - Scheduler state encoding.
package blink_pkg;

    localparam int unsigned DIV_W = 24;
    localparam int unsigned PAT_W = 8;
    localparam int unsigned REP_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// Synchronous step divider: a single-clock clock-enable source.
// Ports:
//   clk_i      - sole clock
//   rst_i      - asynchronous active-high reset
//   en_i       - count while high
//   clr_i      - synchronous clear of the count (wins over en_i)
//   period_i   - step length minus 1, in clk_i cycles
//   tick_o     - combinational; high while enabled and the count equals period_i
module tick_gen
    import blink_pkg::*;
#(
    parameter int unsigned DIV_W = blink_pkg::DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == period_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            // Wrap on the boundary so each step lasts period_i + 1 cycles.
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_blink_sched.sv
// Programmable LED blink scheduler. A config handshake loads step period, pattern and
// repeat count; the pattern is then played onto the LED one bit per step.
// Ports:
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   cfg_valid_i/ready_o   - config handshake (ready only while idle)
//   cfg_period_i          - step length minus 1, in clk_i cycles
//   cfg_pattern_i         - bit i drives the LED during step i
//   cfg_repeat_i          - number of pattern passes, 0 = run until stopped
//   stop_i                - abort a running sequence
//   led_o, tick_o         - registered LED drive, registered step-boundary pulse
//   busy_o, done_o        - registered running flag, registered end-of-sequence pulse
module led_blink_sched
    import blink_pkg::*;
#(
    parameter int unsigned DIV_W = blink_pkg::DIV_W,
    parameter int unsigned PAT_W = blink_pkg::PAT_W,
    parameter int unsigned REP_W = blink_pkg::REP_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [DIV_W-1:0] cfg_period_i,
    input  logic [PAT_W-1:0] cfg_pattern_i,
    input  logic [REP_W-1:0] cfg_repeat_i,
    input  logic             stop_i,
    output logic             led_o,
    output logic             tick_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    state_e             state_q;
    logic [DIV_W-1:0]   period_q;
    logic [PAT_W-1:0]   pattern_q;
    logic [REP_W-1:0]   repeat_q;
    logic [IDX_W-1:0]   bit_idx_q;
    logic [REP_W-1:0]   pass_cnt_q;
    logic               led_q, tick_q, busy_q, done_q;

    logic               step_tick;
    logic               accept;
    logic               abort;
    logic [IDX_W-1:0]   idx_nxt;

    assign accept  = (state_q == ST_IDLE) && cfg_valid_i;
    assign abort   = (state_q == ST_RUN) && stop_i;
    assign idx_nxt = bit_idx_q + 1'b1;

    tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (state_q == ST_RUN),
        .clr_i    (accept || abort),
        .period_i (period_q),
        .tick_o   (step_tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            period_q   <= '0;
            pattern_q  <= '0;
            repeat_q   <= '0;
            bit_idx_q  <= '0;
            pass_cnt_q <= '0;
            led_q      <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid_i) begin
                        period_q   <= cfg_period_i;
                        pattern_q  <= cfg_pattern_i;
                        repeat_q   <= cfg_repeat_i;
                        bit_idx_q  <= '0;
                        pass_cnt_q <= '0;
                        led_q      <= cfg_pattern_i[0];
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // stop wins over a coincident step boundary: no tick on abort.
                    if (stop_i) begin
                        led_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (step_tick) begin
                        tick_q <= 1'b1;
                        if (bit_idx_q != LAST_IDX) begin
                            bit_idx_q <= idx_nxt;
                            led_q     <= pattern_q[idx_nxt];
                        end else if ((repeat_q == '0) || (pass_cnt_q != repeat_q - 1'b1)) begin
                            bit_idx_q <= '0;
                            led_q     <= pattern_q[0];
                            // Endless mode leaves pass_cnt alone so it never wraps.
                            if (repeat_q != '0) begin
                                pass_cnt_q <= pass_cnt_q + 1'b1;
                            end
                        end else begin
                            led_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign cfg_ready_o = (state_q == ST_IDLE);
    assign led_o       = led_q;
    assign tick_o      = tick_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_led_blink_sched.sv
// Self-checking bench for led_blink_sched. A cycle model of the schedule fills a
// scoreboard when each config is driven; entries are popped and compared one per clock.
module tb_led_blink_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [23:0] cfg_period;
    logic [7:0]  cfg_pattern;
    logic [7:0]  cfg_repeat;
    logic        stop;
    logic        led, tick, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] sb_q[$];
    logic [4:0] obs;
    logic [4:0] exp_v;

    always #5 clk = ~clk;

    led_blink_sched dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_period_i  (cfg_period),
        .cfg_pattern_i (cfg_pattern),
        .cfg_repeat_i  (cfg_repeat),
        .stop_i        (stop),
        .led_o         (led),
        .tick_o        (tick),
        .busy_o        (busy),
        .done_o        (done)
    );

    assign obs = {cfg_ready, busy, led, tick, done};

    // Expected {ready,busy,led,tick,done} just after edge k+n, config accepted at edge k.
    function automatic logic [4:0] model(int p, logic [7:0] pat, int r, int n);
        int per;
        int tot;
        int step;
        per = p + 1;
        tot = r * 8 * per;
        if (n == 0) return {1'b0, 1'b1, pat[0], 1'b0, 1'b0};
        if (r != 0 && n == tot) return 5'b10011;
        if (r != 0 && n > tot) return 5'b10000;
        step = (n / per) % 8;
        return {1'b0, 1'b1, pat[step], (n % per) == 0, 1'b0};
    endfunction

    function automatic void push_exp(int p, logic [7:0] pat, int r, int n_from, int n_to);
        for (int n = n_from; n <= n_to; n++) sb_q.push_back(model(p, pat, r, n));
    endfunction

    function automatic logic [4:0] pop_exp();
        if (sb_q.size() == 0) return 5'bxxxxx;
        return sb_q.pop_front();
    endfunction

    // Offer a config; it is taken on the next rising edge.
    task automatic start_cfg(int p, logic [7:0] pat, int r);
        cfg_valid   = 1'b1;
        cfg_period  = 24'(p);
        cfg_pattern = pat;
        cfg_repeat  = 8'(r);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_period = '0;
        cfg_pattern = '0;
        cfg_repeat = '0;
        stop = 1'b0;
        #12;
        n_checks++;
        if (obs !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_hold got=%b expected=%b", obs, 5'b10000);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_idle got=%b expected=%b", obs, 5'b10000);
        end
    endtask

    task automatic test_single_pass();
        int ticks;
        ticks = 0;
        push_exp(3, 8'b1010_0011, 1, 0, 34);
        start_cfg(3, 8'b1010_0011, 1);
        for (int n = 0; n <= 34; n++) begin
            @(posedge clk); #1;
            if (n == 0) cfg_valid = 1'b0;
            if (tick === 1'b1) ticks++;
            exp_v = pop_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL single_pass n=%0d got=%b expected=%b", n, obs, exp_v);
            end
        end
        n_checks++;
        if (ticks != 8) begin
            n_fail++;
            $display("FAIL single_pass_ticks got=%0d expected=8", ticks);
        end
    endtask

    task automatic test_repeat_p0();
        push_exp(0, 8'hF0, 3, 0, 26);
        start_cfg(0, 8'hF0, 3);
        for (int n = 0; n <= 26; n++) begin
            @(posedge clk); #1;
            if (n == 0) cfg_valid = 1'b0;
            exp_v = pop_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL repeat_p0 n=%0d got=%b expected=%b", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_stop_mid();
        push_exp(9, 8'h5C, 0, 0, 56);
        sb_q.push_back(5'b10001);
        start_cfg(9, 8'h5C, 0);
        for (int n = 0; n <= 57; n++) begin
            @(posedge clk); #1;
            if (n == 0) cfg_valid = 1'b0;
            exp_v = pop_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stop_mid n=%0d got=%b expected=%b", n, obs, exp_v);
            end
            if (n == 56) stop = 1'b1;
            if (n == 57) stop = 1'b0;
        end
        // Re-arm in the cycle right after done.
        push_exp(0, 8'h81, 1, 0, 9);
        start_cfg(0, 8'h81, 1);
        for (int n = 0; n <= 9; n++) begin
            @(posedge clk); #1;
            if (n == 0) cfg_valid = 1'b0;
            exp_v = pop_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stop_rearm n=%0d got=%b expected=%b", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_stop_boundary();
        push_exp(4, 8'hA5, 0, 0, 9);
        sb_q.push_back(5'b10001);
        sb_q.push_back(5'b10000);
        start_cfg(4, 8'hA5, 0);
        for (int n = 0; n <= 11; n++) begin
            @(posedge clk); #1;
            if (n == 0) cfg_valid = 1'b0;
            exp_v = pop_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stop_boundary n=%0d got=%b expected=%b", n, obs, exp_v);
            end
            // Sampled at edge 10, which is a step boundary for period 4.
            if (n == 9) stop = 1'b1;
            if (n == 10) stop = 1'b0;
        end
    endtask

    task automatic test_ignored_cfg();
        push_exp(1, 8'h3C, 1, 0, 18);
        start_cfg(1, 8'h3C, 1);
        for (int n = 0; n <= 18; n++) begin
            @(posedge clk); #1;
            if (n == 0) cfg_valid = 1'b0;
            exp_v = pop_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL ignored_cfg n=%0d got=%b expected=%b", n, obs, exp_v);
            end
            if (n == 5) start_cfg(0, 8'hFF, 0);
            if (n == 7) cfg_valid = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        push_exp(2, 8'h6B, 0, 0, 7);
        start_cfg(2, 8'h6B, 0);
        for (int n = 0; n <= 7; n++) begin
            @(posedge clk); #1;
            if (n == 0) cfg_valid = 1'b0;
            exp_v = pop_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL async_pre n=%0d got=%b expected=%b", n, obs, exp_v);
            end
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 5'b10000) begin
            n_fail++;
            $display("FAIL async_reset got=%b expected=%b", obs, 5'b10000);
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        push_exp(2, 8'h6B, 0, 0, 12);
        start_cfg(2, 8'h6B, 0);
        for (int n = 0; n <= 12; n++) begin
            @(posedge clk); #1;
            if (n == 0) cfg_valid = 1'b0;
            exp_v = pop_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL async_post n=%0d got=%b expected=%b", n, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_repeat_p0();
        test_stop_mid();
        test_stop_boundary();
        test_ignored_cfg();
        test_async_reset();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
